// File: rtl/bus_fanout_pkg.sv
// pocket: shared types and constants for the bus fan-out block.
package pocket;
  typedef enum logic {IDLE, WAIT} bus_fanout_state_t;
  localparam logic [31:0] BUS_DEFAULT_RD_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/bus_fanout_if.sv
// bus_if: single-cycle write/read-request bus with a later rd_data_valid return.
interface bus_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_valid;
  modport master (output addr, wr, wr_data, rd, input rd_data, rd_data_valid);
  modport slave (input addr, wr, wr_data, rd, output rd_data, rd_data_valid);
endinterface

// File: rtl/bus_fanout_addr_decode.sv
// bus_addr_decode: one-hot window decode of an address, lowest matching index wins.
module bus_addr_decode #(
  parameter int NUM_LEAVES = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0]                 addr,
  input  logic [NUM_LEAVES-1:0][ADDR_WIDTH-1:0] leaf_base,
  input  logic [NUM_LEAVES-1:0][ADDR_WIDTH-1:0] leaf_mask,
  output logic [NUM_LEAVES-1:0]                 sel,
  output logic                                  hit
);
  always_comb begin
    sel = '0;
    for (int i = NUM_LEAVES - 1; i >= 0; i--)
      if ((addr & leaf_mask[i]) == leaf_base[i]) sel = NUM_LEAVES'(1) << i;
  end
  assign hit = |sel;
endmodule

// File: rtl/bus_fanout.sv
// bus_fanout: one-to-N bus splitter with address decode and a single
// outstanding read merged back through a registered response path.
module bus_fanout
  import pocket::*;
#(
  parameter int NUM_LEAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [NUM_LEAVES-1:0][ADDR_WIDTH-1:0] LEAF_BASE = '0,
  parameter logic [NUM_LEAVES-1:0][ADDR_WIDTH-1:0] LEAF_MASK = '0,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_RD_DATA = DATA_WIDTH'(BUS_DEFAULT_RD_DATA)
) (
  input  logic clk,
  input  logic reset,
  bus_if.slave root,
  bus_if.master leaf [NUM_LEAVES],
  input  logic err_clear,
  output logic err_timeout,
  output logic err_unmapped
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  bus_fanout_state_t r_state, w_next;
  logic [NUM_LEAVES-1:0] w_sel, r_sel, w_vld;
  logic [NUM_LEAVES-1:0][DATA_WIDTH-1:0] w_rdata;
  logic [DATA_WIDTH-1:0] w_leaf_data, r_data;
  logic [CW-1:0] r_cnt;
  logic w_hit, w_idle, w_start, w_leaf_ok, w_to, w_done, w_unm_rd, w_unm, r_vld, r_err_to, r_err_um;
  bus_addr_decode #(.NUM_LEAVES(NUM_LEAVES), .ADDR_WIDTH(ADDR_WIDTH)) u_dec (
    .addr(root.addr), .leaf_base(LEAF_BASE), .leaf_mask(LEAF_MASK), .sel(w_sel), .hit(w_hit)
  );
  // Reads are only forwarded from IDLE; a read issued during WAIT is swallowed.
  for (genvar i = 0; i < NUM_LEAVES; i++) begin : g_leaf
    assign leaf[i].addr    = root.addr;
    assign leaf[i].wr_data = root.wr_data;
    assign leaf[i].wr      = root.wr & w_sel[i];
    assign leaf[i].rd      = root.rd & w_sel[i] & w_idle;
    assign w_vld[i]        = leaf[i].rd_data_valid;
    assign w_rdata[i]      = leaf[i].rd_data;
  end
  always_comb begin
    w_leaf_data = '0;
    for (int j = 0; j < NUM_LEAVES; j++) w_leaf_data |= w_rdata[j] & {DATA_WIDTH{r_sel[j]}};
    w_idle    = r_state == IDLE;
    w_start   = w_idle & root.rd & w_hit;
    w_unm_rd  = w_idle & root.rd & ~w_hit;
    w_unm     = ~w_hit & (root.wr | (root.rd & w_idle));
    w_leaf_ok = ~w_idle & |(w_vld & r_sel);
    w_to      = ~w_idle & (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    w_done    = w_leaf_ok | w_to;
    w_next    = w_start ? WAIT : w_done ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_vld    <= 1'b0;
      r_data   <= '0;
      r_cnt    <= '0;
      r_sel    <= '0;
      r_err_to <= 1'b0;
      r_err_um <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_vld    <= w_unm_rd | w_done;
      r_data   <= w_leaf_ok ? w_leaf_data : (w_unm_rd | w_done) ? DEFAULT_RD_DATA : r_data;
      r_cnt    <= w_start ? '0 : (~w_idle & ~w_done) ? r_cnt + CW'(1) : r_cnt;
      r_sel    <= w_start ? w_sel : r_sel;
      r_err_to <= (w_to & ~w_leaf_ok) | (r_err_to & ~err_clear);
      r_err_um <= w_unm | (r_err_um & ~err_clear);
    end
  end
  assign root.rd_data_valid = r_vld;
  assign root.rd_data       = r_data;
  assign err_timeout        = r_err_to;
  assign err_unmapped       = r_err_um;
endmodule

// File: tb/tb_bus_fanout.sv
// tb_bus_fanout: directed checks of decode, forwarding, read return, timeout and reset.
module tb_bus_fanout;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic err_clear = 1'b0;
  logic err_timeout, err_unmapped;
  int total = 0;
  int bad = 0;
  bus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) root_if ();
  bus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) leaf [3] ();
  bus_fanout #(
    .NUM_LEAVES(3), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .LEAF_BASE({32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .LEAF_MASK({3{32'hF000_0000}}),
    .TIMEOUT_CYCLES(8), .DEFAULT_RD_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .reset(reset), .root(root_if), .leaf(leaf),
    .err_clear(err_clear), .err_timeout(err_timeout), .err_unmapped(err_unmapped)
  );
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    chk("reset_valid", {31'd0, root_if.rd_data_valid}, 32'd0);
    chk("reset_data", root_if.rd_data, 32'd0);
    chk("reset_err_to", {31'd0, err_timeout}, 32'd0);
    chk("reset_err_um", {31'd0, err_unmapped}, 32'd0);
    chk("reset_leaf_rd", {29'd0, leaf[2].rd, leaf[1].rd, leaf[0].rd}, 32'd0);
  endtask

  task automatic test_write;
    root_if.addr = 32'h1000_0004; root_if.wr_data = 32'h1234; root_if.wr = 1'b1;
    #1;
    chk("wr_sel", {29'd0, leaf[2].wr, leaf[1].wr, leaf[0].wr}, 32'b010);
    chk("wr_addr1", leaf[1].addr, 32'h1000_0004);
    chk("wr_data1", leaf[1].wr_data, 32'h1234);
    chk("wr_addr_bcast0", leaf[0].addr, 32'h1000_0004);
    chk("wr_data_bcast2", leaf[2].wr_data, 32'h1234);
    tick;
    root_if.wr = 1'b0;
    chk("wr_no_resp", {31'd0, root_if.rd_data_valid}, 32'd0);
    chk("wr_no_err", {31'd0, err_unmapped}, 32'd0);
  endtask

  task automatic test_read;
    root_if.addr = 32'h2000_0010; root_if.rd = 1'b1;
    #1;
    chk("rd_fwd", {29'd0, leaf[2].rd, leaf[1].rd, leaf[0].rd}, 32'b100);
    for (int k = 1; k <= 3; k++) begin
      tick;
      root_if.rd = 1'b0;
      chk("rd_early_valid", {31'd0, root_if.rd_data_valid}, 32'd0);
    end
    leaf[2].rd_data = 32'hCAFE; leaf[2].rd_data_valid = 1'b1;
    tick;
    leaf[2].rd_data_valid = 1'b0;
    chk("rd_valid", {31'd0, root_if.rd_data_valid}, 32'd1);
    chk("rd_data", root_if.rd_data, 32'hCAFE);
    chk("rd_idle", {31'd0, dut.r_state == pocket::IDLE}, 32'd1);
    tick;
    chk("rd_pulse", {31'd0, root_if.rd_data_valid}, 32'd0);
    chk("rd_hold", root_if.rd_data, 32'hCAFE);
  endtask

  task automatic test_unmapped;
    root_if.addr = 32'h5000_0000; root_if.rd = 1'b1;
    #1;
    chk("um_no_fwd", {29'd0, leaf[2].rd, leaf[1].rd, leaf[0].rd}, 32'd0);
    tick;
    root_if.rd = 1'b0;
    chk("um_valid", {31'd0, root_if.rd_data_valid}, 32'd1);
    chk("um_data", root_if.rd_data, 32'hDEAD_BEEF);
    chk("um_err", {31'd0, err_unmapped}, 32'd1);
    chk("um_idle", {31'd0, dut.r_state == pocket::IDLE}, 32'd1);
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    chk("um_clear", {31'd0, err_unmapped}, 32'd0);
    root_if.wr = 1'b1; err_clear = 1'b1;
    #1;
    chk("um_wr_drop", {29'd0, leaf[2].wr, leaf[1].wr, leaf[0].wr}, 32'd0);
    tick;
    root_if.wr = 1'b0; err_clear = 1'b0;
    chk("um_set_prio", {31'd0, err_unmapped}, 32'd1);
    chk("um_wr_no_resp", {31'd0, root_if.rd_data_valid}, 32'd0);
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
  endtask

  task automatic test_timeout;
    root_if.addr = 32'h2000_0000; root_if.rd = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick;
      root_if.rd = 1'b0;
      chk("to_wait_valid", {31'd0, root_if.rd_data_valid}, 32'd0);
    end
    tick;
    chk("to_valid", {31'd0, root_if.rd_data_valid}, 32'd1);
    chk("to_data", root_if.rd_data, 32'hDEAD_BEEF);
    chk("to_err", {31'd0, err_timeout}, 32'd1);
    tick; tick;
    chk("to_sticky", {31'd0, err_timeout}, 32'd1);
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    chk("to_clear", {31'd0, err_timeout}, 32'd0);
  endtask

  task automatic test_edge_timeout;
    root_if.addr = 32'h2000_0000; root_if.rd = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick;
      root_if.rd = 1'b0;
    end
    leaf[2].rd_data = 32'hABCD; leaf[2].rd_data_valid = 1'b1;
    tick;
    leaf[2].rd_data_valid = 1'b0;
    chk("edge_valid", {31'd0, root_if.rd_data_valid}, 32'd1);
    chk("edge_data", root_if.rd_data, 32'hABCD);
    chk("edge_no_err", {31'd0, err_timeout}, 32'd0);
  endtask

  task automatic test_back_to_back;
    int n = 0;
    root_if.addr = 32'h2000_0010; root_if.rd = 1'b1;
    leaf[2].rd_data = 32'h7777; leaf[2].rd_data_valid = 1'b1;
    tick;
    root_if.rd = 1'b0; leaf[2].rd_data_valid = 1'b0;
    chk("b2b_zero_lat", {31'd0, root_if.rd_data_valid}, 32'd0);
    root_if.addr = 32'h1000_0000; root_if.rd = 1'b1;
    leaf[0].rd_data = 32'h1111; leaf[0].rd_data_valid = 1'b1;
    #1;
    chk("b2b_no_fwd", {29'd0, leaf[2].rd, leaf[1].rd, leaf[0].rd}, 32'd0);
    tick;
    root_if.rd = 1'b0; leaf[0].rd_data_valid = 1'b0;
    chk("b2b_spurious", {31'd0, root_if.rd_data_valid}, 32'd0);
    root_if.addr = 32'h0000_0008; root_if.wr = 1'b1;
    #1;
    chk("b2b_wr_fwd", {29'd0, leaf[2].wr, leaf[1].wr, leaf[0].wr}, 32'b001);
    leaf[2].rd_data = 32'hBEEF_0002; leaf[2].rd_data_valid = 1'b1;
    tick;
    root_if.wr = 1'b0; leaf[2].rd_data_valid = 1'b0;
    chk("b2b_data", root_if.rd_data, 32'hBEEF_0002);
    for (int k = 0; k < 12; k++) begin
      n += int'(root_if.rd_data_valid);
      tick;
    end
    chk("b2b_one_resp", n, 32'd1);
  endtask

  task automatic test_reset_mid;
    root_if.addr = 32'h2000_0000; root_if.rd = 1'b1;
    tick;
    root_if.rd = 1'b0; root_if.wr = 1'b1; root_if.addr = 32'h6000_0000;
    tick;
    root_if.wr = 1'b0; reset = 1'b1;
    tick;
    reset = 1'b0;
    leaf[2].rd_data = 32'h5555; leaf[2].rd_data_valid = 1'b1;
    tick;
    leaf[2].rd_data_valid = 1'b0;
    chk("rst_mid_valid", {31'd0, root_if.rd_data_valid}, 32'd0);
    chk("rst_mid_data", root_if.rd_data, 32'd0);
    chk("rst_mid_err", {30'd0, err_timeout, err_unmapped}, 32'd0);
    chk("rst_mid_idle", {31'd0, dut.r_state == pocket::IDLE}, 32'd1);
    tick;
    chk("rst_mid_late", {31'd0, root_if.rd_data_valid}, 32'd0);
  endtask

  initial begin
    root_if.addr = '0; root_if.wr = 1'b0; root_if.wr_data = '0; root_if.rd = 1'b0;
    leaf[0].rd_data = '0; leaf[0].rd_data_valid = 1'b0;
    leaf[1].rd_data = '0; leaf[1].rd_data_valid = 1'b0;
    leaf[2].rd_data = '0; leaf[2].rd_data_valid = 1'b0;
    tick;
    test_reset;
    test_write;
    test_read;
    test_unmapped;
    test_timeout;
    test_edge_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
